// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/DIV sequencer owning HI/LO for the MIPS pipeline
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic        md_pending,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
  state_t      state_q;
  logic [3:0]  cnt_q, op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q, done_q;
  logic        is_md, accept;
  logic [63:0] prod_s, prod_u, prod;
  logic        is_mul, na, nb, wr_d;
  logic [31:0] abs_a, abs_b, uq, ur, hi_d, lo_d;
  assign is_md      = (op >= OP_MULT) && (op <= OP_DIVU);
  assign accept     = start && !cancel && (state_q == IDLE);
  assign md_pending = busy_q || (start && is_md && !cancel);
  assign rd_data    = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign HI         = hi_q;
  assign LO         = lo_q;
  // Result of the latched operation; signed divide works on magnitudes then fixes signs
  always_comb begin
    is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod   = (op_q == OP_MULT) ? prod_s : prod_u;
    na     = (op_q == OP_DIV) && a_q[31];
    nb     = (op_q == OP_DIV) && b_q[31];
    abs_a  = na ? -a_q : a_q;
    abs_b  = nb ? -b_q : b_q;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    hi_d   = is_mul ? prod[63:32] : (na ? -ur : ur);
    lo_d   = is_mul ? prod[31:0] : ((na ^ nb) ? -uq : uq);
    wr_d   = is_mul || (b_q != 32'd0);
  end
  // Sequencer: accept in IDLE, count down in RUN, commit HI/LO on the last busy cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && is_md) begin
          op_q    <= op;
          a_q     <= A;
          b_q     <= B;
          cnt_q   <= (op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        if (accept && op == OP_MTHI) hi_q <= A;
        if (accept && op == OP_MTLO) lo_q <= A;
      end else begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (wr_d) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
        end
      end
    end
  end
endmodule
